adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Downstream capture-and-check stage for the 6-bit carry-select adder under characterization. Each cycle it can accept one launched operand pair together with the adder's combinational `sum`/`cout`. It compares the result against a golden `i_add_term1 + i_add_term2` and buffers `{cout, sum, mismatch}` in a small FIFO for the classification/logging consumer. It also keeps running transaction and error counters.

## Interface
- `WIDTH`, default 6: operand and sum width; must match the adder under test.
- `DEPTH`, default 4: result FIFO depth; power of two, ≥2.
- `CNT_W`, default 16: width of the transaction and error counters.
- `i_clk`  in  1: the single clock; all state updates on its rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_valid`  in  1: the operand/result set on the inputs is valid this cycle.
- `o_ready`  out  1: the stage can accept a set this cycle.
- `i_add_term1`  in  WIDTH: operand A as launched to the adder.
- `i_add_term2`  in  WIDTH: operand B as launched to the adder.
- `i_sum`  in  WIDTH: adder `sum` output, same cycle as the operands.
- `i_cout`  in  1: adder `cout` output, same cycle as the operands.
- `o_valid`  out  1: FIFO head holds a result.
- `i_ready`  in  1: the consumer takes the head this cycle.
- `o_sum`  out  WIDTH: head entry sum.
- `o_cout`  out  1: head entry carry.
- `o_mismatch`  out  1: head entry failed the golden compare.
- `o_txn_count`  out  CNT_W: number of accepted sets.
- `o_err_count`  out  CNT_W: number of accepted sets with a mismatch.
- `i_clear`  in  1: synchronous clear of both counters. It does not touch the FIFO.

## Operation
- **Accept:** a set is accepted when `i_valid && o_ready`. `o_ready = !full`.
  - `o_ready` depends only on FIFO state. It is low when full even if a pop occurs in the same cycle.
- **Golden compare:** `golden = {1'b0,i_add_term1} + {1'b0,i_add_term2}`, computed at WIDTH+1 bits. `mismatch = ({i_cout,i_sum} != golden)`. The compare is purely combinational on the accept cycle and is stored with the entry.
- **FIFO storage:** DEPTH entries of WIDTH+2 bits. Write and read pointers are `log2(DEPTH)+1` bits wide, and the MSB distinguishes full from empty.
  - Pointers wrap modulo DEPTH.
  - `empty = (wptr == rptr)`.
  - `full` means the low bits are equal and the MSBs differ.
- **Pop:** a pop occurs on `o_valid && i_ready`. `o_sum`/`o_cout`/`o_mismatch` show the head entry directly from storage; there is no output register. When empty, these outputs are 0.
- **Push and pop together:** when the FIFO is non-empty and not full, both happen in the same cycle and the occupancy is unchanged.
- **Pop when empty:** `i_ready` with an empty FIFO has no effect.
- **Push when full:** `i_valid` while full is not accepted. The set is not counted, and the upstream must hold it.
- **Counters:** on accept, `o_txn_count` increments by 1. If `mismatch` is set, `o_err_count` also increments by 1.
  - Both counters saturate at all-ones and do not wrap.
- **Clear:** `i_clear` has priority over an increment in the same cycle. Both counters become 0 and that cycle's accept is not counted. That cycle's data is still written to the FIFO.
- **Reset:** asserting `i_rst_n` low at any time, including mid-stream, immediately clears all state:
  - pointers, so the FIFO is empty and contents are discarded;
  - both counters.

  Storage contents need not be reset, but the head outputs are forced to 0 while empty.

## Timing
- **Reset values:** `o_ready=1`, `o_valid=0`, `o_sum=0`, `o_cout=0`, `o_mismatch=0`, `o_txn_count=0`, `o_err_count=0`.
- **Latency:** a set accepted at edge N appears at the head with `o_valid=1` immediately after edge N, provided the FIFO was empty. Counters also reflect it after edge N.
- **Throughput:** one accept and one pop per cycle, sustained.
- **Combinational paths:**
  - There is no combinational path from `i_valid` or `i_ready` to `o_ready` or `o_valid`.
  - The only combinational path through the block runs from the data inputs to the internal compare, which is registered into the FIFO.
- **Reset release:** after `i_rst_n` deasserts, the first accept can occur on the first rising edge.

## Test plan
- **Reset values:** hold `i_rst_n=0` for 3 cycles, then release. All outputs equal the reset values, and `o_ready=1`.
- **Correct result:** A=3, B=5, `i_sum=8`, `i_cout=0`, one accept.
  - Next cycle: `o_valid=1`, `o_sum=8`, `o_mismatch=0`, `o_txn_count=1`, `o_err_count=0`.
- **Carry and fault detection:**
  - Correct carry case: A=63, B=1, `i_sum=0`, `i_cout=1`, so `o_mismatch=0`.
  - Then a faulted adder output (`i_sum=6'h0F` for A=B=31, which should give 62): `o_mismatch=1`, and `o_err_count` goes 0→1.
- **Backpressure and wrap-around:** hold `i_ready=0` and push 5 sets with `DEPTH=4`.
  - `o_ready` drops after the 4th accept, and the 5th is not counted (`o_txn_count=4`).
  - Then pop all entries. They come out in order, and `o_valid` drops after the 4th pop.
  - Repeat twice to exercise pointer wrap-around.
- **Simultaneous events:**
  - With 2 entries, push and pop in the same cycle: occupancy stays 2 and order is preserved.
  - Assert `i_clear` together with a mismatching accept: both counters end at 0, and the entry is still present with `o_mismatch=1`.
- **Reset mid-stream and saturation:**
  - With 3 entries queued, pulse `i_rst_n` low between edges: `o_valid` falls immediately and the counters read 0.
  - With `CNT_W=3`, do 9 accepts: `o_txn_count` saturates at 7.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker: golden-compare adder results into a FIFO and keep transaction/error counters
module adder_result_checker #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_txn_count,
  output logic [CNT_W-1:0] o_err_count,
  input  logic             i_clear
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [WIDTH:0] golden;
  logic mismatch, empty, full, push, pop;
  assign golden = {1'b0, i_add_term1} + {1'b0, i_add_term2};
  assign mismatch = {i_cout, i_sum} != golden;
  assign empty = wptr == rptr;
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign o_ready = !full;
  assign o_valid = !empty;
  assign push = i_valid && !full;
  assign pop = !empty && i_ready;
  assign {o_cout, o_sum, o_mismatch} = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge i_clk)
    if (push) mem[wptr[AW-1:0]] <= {i_cout, i_sum, mismatch};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
      o_txn_count <= '0;
      o_err_count <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (i_clear) begin
        o_txn_count <= '0;
        o_err_count <= '0;
      end else if (push) begin
        if (~&o_txn_count) o_txn_count <= o_txn_count + CNT_W'(1);
        if (mismatch && ~&o_err_count) o_err_count <= o_err_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: scoreboard bench for adder_result_checker
module tb_adder_result_checker;
  logic clk = 0, rst_n = 0, valid = 0, ready = 0, cout = 0, clear = 0;
  logic [5:0] a = 0, b = 0, sum = 0;
  logic o_ready, o_valid, o_cout, o_mismatch;
  logic [5:0] o_sum;
  logic [15:0] txn, err;
  logic s_ready, s_valid, s_cout, s_mismatch;
  logic [5:0] s_sum;
  logic [2:0] s_txn, s_err;
  logic [7:0] q[$];
  int total = 0, bad = 0, occ = 0, e_txn = 0, e_err = 0, e_stxn = 0, e_serr = 0;

  always #5 clk = ~clk;

  adder_result_checker dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_add_term1(a), .i_add_term2(b), .i_sum(sum), .i_cout(cout),
    .o_valid(o_valid), .i_ready(ready), .o_sum(o_sum), .o_cout(o_cout),
    .o_mismatch(o_mismatch), .o_txn_count(txn), .o_err_count(err), .i_clear(clear));

  adder_result_checker #(.CNT_W(3)) sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s_ready),
    .i_add_term1(a), .i_add_term2(b), .i_sum(sum), .i_cout(cout),
    .o_valid(s_valid), .i_ready(ready), .o_sum(s_sum), .o_cout(s_cout),
    .o_mismatch(s_mismatch), .o_txn_count(s_txn), .o_err_count(s_err), .i_clear(clear));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && o_valid && ready) begin
      if (q.size() == 0) chk("underflow", 1, 0);
      else chk("head", {o_cout, o_sum, o_mismatch}, q.pop_front());
    end

  task automatic step(input int v, input int ta, input int tb, input int s, input int c,
                      input int r, input int clr);
    logic acc, pp, mm;
    valid = v[0]; a = ta[5:0]; b = tb[5:0]; sum = s[5:0]; cout = c[0];
    ready = r[0]; clear = clr[0];
    chk("o_ready", o_ready, occ < 4);
    chk("o_valid", o_valid, occ > 0);
    if (occ == 0) chk("empty_head", {o_cout, o_sum, o_mismatch}, 0);
    acc = v[0] && occ < 4;
    pp = r[0] && occ > 0;
    mm = {c[0], s[5:0]} != ta + tb;
    if (acc) q.push_back({c[0], s[5:0], mm});
    if (clr[0]) begin
      e_txn = 0; e_err = 0; e_stxn = 0; e_serr = 0;
    end else if (acc) begin
      e_txn++;
      if (e_stxn < 7) e_stxn++;
      if (mm) begin
        e_err++;
        if (e_serr < 7) e_serr++;
      end
    end
    @(posedge clk); #1;
    occ = occ + int'(acc) - int'(pp);
    chk("txn", txn, e_txn);
    chk("err", err, e_err);
    chk("sat_txn", s_txn, e_stxn);
    chk("sat_err", s_err, e_serr);
  endtask

  task automatic idle(input int r);
    step(0, 0, 0, 0, 0, r, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_head", {o_cout, o_sum, o_mismatch}, 0);
    chk("rst_txn", txn, 0);
    chk("rst_err", err, 0);
    step(1, 3, 5, 8, 0, 0, 0);
    chk("t1_sum", o_sum, 8);
    chk("t1_mm", o_mismatch, 0);
    idle(1);
    step(1, 63, 1, 0, 1, 0, 0);
    chk("carry_cout", o_cout, 1);
    chk("carry_mm", o_mismatch, 0);
    idle(1);
    step(1, 31, 31, 6'h0f, 0, 0, 0);
    chk("fault_mm", o_mismatch, 1);
    chk("fault_err", err, 1);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) step(1, i + 10 * k, 7, i + 10 * k + 7, 0, 0, 0);
      chk("bp_ready", o_ready, 0);
      for (int i = 0; i < 4; i++) idle(1);
      chk("bp_drained", o_valid, 0);
    end
    chk("bp_txn", txn, 15);
    step(1, 1, 2, 3, 0, 0, 0);
    step(1, 4, 4, 9, 0, 0, 0);
    step(1, 5, 6, 11, 0, 1, 0);
    chk("pp_occ", occ, 2);
    idle(1);
    idle(1);
    step(1, 2, 2, 5, 0, 0, 1);
    chk("clr_txn", txn, 0);
    chk("clr_err", err, 0);
    chk("clr_mm", o_mismatch, 1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, i, i, 2 * i, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("mid_valid", o_valid, 0);
    chk("mid_txn", txn, 0);
    chk("mid_err", err, 0);
    q.delete();
    occ = 0; e_txn = 0; e_err = 0; e_stxn = 0; e_serr = 0;
    #1 rst_n = 1;
    for (int i = 0; i < 9; i++) step(1, i, 3 * i, 4 * i, 0, 1, 0);
    chk("sat7", s_txn, 7);
    chk("nosat9", txn, 9);
    idle(1);
    idle(0);
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
